pe_input_router: RTL and testbench
==================================

# pe_input_router

Clocked, parametrised input router at the front of each processing element. It accepts one tagged word per cycle from the PE's network-interface side and steers it to the ifmap channel or to one of `NUM_ROWS` filter-row channels. A filter word can also be broadcast to all rows at once. Every output owns a small FIFO, so a stalled consumer does not block traffic to the others. Out-of-range row tags are caught and dropped, and the block keeps a per-row load mask for the PE controller.

## Interface
- `NUM_ROWS`, 3, number of filter-row outputs (≥1).
- `FILTER_WIDTH`, 8, bits per filter tap; a filter word is `NUM_ROWS*FILTER_WIDTH` bits.
- `IFMAP_WIDTH`, 9, ifmap word width; must be ≤ `NUM_ROWS*FILTER_WIDTH`.
- `FIFO_DEPTH`, 2, entries per output FIFO (power of two, ≥2).
- `ROW_W`, `$clog2(NUM_ROWS)` (min 1), derived row-tag width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid` / `in_ready`  in/out  1  input handshake; a word transfers when both are high.
- `in_data`  in  `NUM_ROWS*FILTER_WIDTH`  payload.
- `in_is_filter`  in  1  0 = ifmap word, 1 = filter word.
- `in_bcast`  in  1  filter only: write to every row FIFO.
- `in_row`  in  `ROW_W`  target filter row (ignored when `in_bcast`=1).
- `ifmap_valid` / `ifmap_ready` / `ifmap_data`  out/in/out  1/1/`IFMAP_WIDTH`  ifmap output = `in_data[IFMAP_WIDTH-1:0]`.
- `row_valid` / `row_ready`  out/in  `NUM_ROWS`  per-row handshake.
- `row_data`  out  `NUM_ROWS*NUM_ROWS*FILTER_WIDTH`  row r occupies slice r.
- `row_loaded`  out  `NUM_ROWS`  sticky bit per row, set when a filter word is accepted for that row.
- `rows_all_loaded`  out  1  single-cycle pulse on the cycle `row_loaded` becomes all ones.
- `load_clr`  in  1  synchronous clear of `row_loaded`.
- `err_row`  out  1  sticky: a filter word with `in_row ≥ NUM_ROWS` (non-broadcast) was received.
- `err_clr`  in  1  synchronous clear of `err_row`.

## Operation
- Destination decode: ifmap, row[`in_row`], all rows (broadcast), or invalid (filter, no bcast, `in_row ≥ NUM_ROWS`).
- `in_ready`, combinational:
  - ifmap: ifmap FIFO not full.
  - single row: that row FIFO not full.
  - broadcast: every row FIFO not full.
  - invalid: always 1.
- On accept, the word is pushed to the target FIFO or FIFOs. Broadcast writes all row FIFOs in the same cycle and is never partial.
- Invalid word: accepted and discarded; `err_row` set. No FIFO and no `row_loaded` bit changes.
- `row_loaded[r]` is set on accept of a single-row word for r, or of a broadcast (all bits).
- `rows_all_loaded` pulses once on the 0→all-ones transition of the mask. It does not repeat until the mask is cleared.
- `load_clr` or `err_clr` in the same cycle as a set event: the set wins for that cycle's event (clear first, then set).
- FIFO outputs are first-word-fall-through with the registered storage below; `*_valid` = FIFO not empty.
- Full-FIFO rule: `in_ready` uses the registered full flag only. A word is not accepted into a full FIFO even when that FIFO pops in the same cycle.
- Ordering is preserved per output. There is no ordering guarantee across different outputs.

## Timing
- Reset values:
  - all FIFOs empty, so `ifmap_valid`=0 and `row_valid`=0;
  - `row_loaded`=0, `rows_all_loaded`=0, `err_row`=0;
  - `ifmap_data`/`row_data`=0.
- `in_ready` after reset equals 1 for every destination.
- Latency: a word accepted at edge N is visible on the output with valid=1 after edge N; the consumer can take it at edge N+1.
- Throughput: one accept per cycle when the target FIFO has space. A sustained full-rate stream needs `FIFO_DEPTH` ≥ 2.
- Push and pop on a non-full, non-empty FIFO in the same cycle leave the count unchanged.
- `reset` asserted mid-transfer: FIFO contents are lost and all outputs return to reset values immediately (asynchronously). The upstream sender must re-send.
- Pointer wrap: pointers are `$clog2(FIFO_DEPTH)+1` bits; full/empty is determined by the MSB comparison.

## Structure
- Shared package `pe_pkg`:
  - `typedef enum logic [1:0] {DST_IFMAP, DST_ROW, DST_BCAST, DST_INVALID} route_t`;
  - default width constants.
- Sub-module `pe_sync_fifo #(WIDTH, DEPTH)`: clk, async active-high reset, push/full, pop/empty, FWFT data. Instantiate `NUM_ROWS`+1 copies.
- The top level holds the decode, ready logic, load mask and error flag.

## Test plan
- Reset, then ifmap word `in_data`=0x1A5 with `ifmap_ready`=1 → `ifmap_data`=0x1A5 valid one cycle after accept; no row valid asserted.
- Filter words 0x112233, 0x445566, 0x778899 to rows 0, 1, 2 → each appears only on its row. `row_loaded` walks 001, 011, 111; `rows_all_loaded` pulses once on the third accept.
- `row_ready[1]`=0, three words to row 1 with `FIFO_DEPTH`=2 → two accepted, `in_ready`=0 on the third. A row 0 word in the next cycle is accepted. Raising `row_ready[1]` drains 2 words in order, then the third is accepted.
- Broadcast 0xABCDEF with row 2 FIFO full → stalls with no partial writes. After row 2 drains one entry it is accepted, and all three rows output 0xABCDEF.
- Filter word with `in_row`=3 (`NUM_ROWS`=3) → accepted, dropped, `err_row`=1 held until `err_clr`. No output or mask change.
- Reset asserted while two rows hold data → all valids drop in the same cycle; mask and error cleared.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and default widths for the PE input router.
package pe_pkg;

  typedef enum logic [1:0] {DST_IFMAP, DST_ROW, DST_BCAST, DST_INVALID} route_t;

  localparam int NUM_ROWS_DEF     = 3;
  localparam int FILTER_WIDTH_DEF = 8;
  localparam int IFMAP_WIDTH_DEF  = 9;
  localparam int FIFO_DEPTH_DEF   = 2;

endpackage

// File: rtl/pe_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry one extra wrap bit.
module pe_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // full gates the push even when the same cycle pops, so ready never depends on pop
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pe_input_router.sv
// Steers tagged words to the ifmap FIFO or per-row filter FIFOs; tracks load mask and bad-row errors.
module pe_input_router import pe_pkg::*; #(
  parameter int  NUM_ROWS     = NUM_ROWS_DEF,
  parameter int  FILTER_WIDTH = FILTER_WIDTH_DEF,
  parameter int  IFMAP_WIDTH  = IFMAP_WIDTH_DEF,
  parameter int  FIFO_DEPTH   = FIFO_DEPTH_DEF,
  localparam int ROW_W        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int FW           = NUM_ROWS * FILTER_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FW-1:0]          in_data,
  input  logic                   in_is_filter,
  input  logic                   in_bcast,
  input  logic [ROW_W-1:0]       in_row,
  output logic                   ifmap_valid,
  input  logic                   ifmap_ready,
  output logic [IFMAP_WIDTH-1:0] ifmap_data,
  output logic [NUM_ROWS-1:0]    row_valid,
  input  logic [NUM_ROWS-1:0]    row_ready,
  output logic [NUM_ROWS*FW-1:0] row_data,
  output logic [NUM_ROWS-1:0]    row_loaded,
  output logic                   rows_all_loaded,
  input  logic                   load_clr,
  output logic                   err_row,
  input  logic                   err_clr
);
  route_t route;
  logic [NUM_ROWS-1:0] row_sel, row_full, row_empty, row_push, loaded_next;
  logic ifmap_full, ifmap_empty, accept;

  always_comb begin
    route = DST_IFMAP;
    if (in_is_filter) begin
      if (in_bcast)                                      route = DST_BCAST;
      else if ({1'b0, in_row} < (ROW_W+1)'(NUM_ROWS))    route = DST_ROW;
      else                                               route = DST_INVALID;
    end
  end

  always_comb begin
    in_ready = 1'b1;
    case (route)
      DST_IFMAP: in_ready = ~ifmap_full;
      DST_ROW:   in_ready = ~|(row_full & row_sel);
      DST_BCAST: in_ready = ~|row_full;
      default:   in_ready = 1'b1;
    endcase
  end

  assign accept      = in_valid & in_ready;
  assign row_push    = ({NUM_ROWS{accept && route == DST_BCAST}}) |
                       ({NUM_ROWS{accept && route == DST_ROW}} & row_sel);
  assign loaded_next = (load_clr ? '0 : row_loaded) | row_push;
  assign ifmap_valid = ~ifmap_empty;
  assign row_valid   = ~row_empty;

  pe_sync_fifo #(.WIDTH(IFMAP_WIDTH), .DEPTH(FIFO_DEPTH)) u_ifmap_fifo (
    .clk(clk), .reset(reset),
    .push(accept && route == DST_IFMAP), .push_data(in_data[IFMAP_WIDTH-1:0]), .full(ifmap_full),
    .pop(ifmap_ready), .empty(ifmap_empty), .pop_data(ifmap_data)
  );

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    assign row_sel[r] = (in_row == ROW_W'(r));
    pe_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_row_fifo (
      .clk(clk), .reset(reset),
      .push(row_push[r]), .push_data(in_data), .full(row_full[r]),
      .pop(row_ready[r]), .empty(row_empty[r]), .pop_data(row_data[r*FW +: FW])
    );
  end

  // clear is applied first so a same-cycle set survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_loaded      <= '0;
      rows_all_loaded <= 1'b0;
      err_row         <= 1'b0;
    end else begin
      row_loaded      <= loaded_next;
      rows_all_loaded <= (&loaded_next) & ~(&row_loaded);
      err_row         <= (err_clr ? 1'b0 : err_row) | (accept && route == DST_INVALID);
    end
  end

endmodule

// File: tb/tb_pe_input_router.sv
// Directed + random bench for pe_input_router against a queue-based reference model.
module tb_pe_input_router;
  localparam int NR = 3;
  localparam int FW = 24;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_is_filter = 1'b0, in_bcast = 1'b0;
  logic [FW-1:0] in_data = '0;
  logic [1:0] in_row = '0;
  logic in_ready, ifmap_valid, ifmap_ready = 1'b0;
  logic [8:0] ifmap_data;
  logic [NR-1:0] row_valid, row_ready = '0, row_loaded;
  logic [NR*FW-1:0] row_data;
  logic rows_all_loaded, load_clr = 1'b0, err_row, err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] ifq[$];
  logic [FW-1:0] rq[NR][$];
  logic [NR-1:0] m_loaded = '0;
  logic m_pulse = 1'b0, m_err = 1'b0;

  always #5 clk = ~clk;

  pe_input_router dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_is_filter(in_is_filter), .in_bcast(in_bcast), .in_row(in_row),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_loaded(row_loaded), .rows_all_loaded(rows_all_loaded), .load_clr(load_clr),
    .err_row(err_row), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ifmap_valid", 32'(ifmap_valid), 32'(ifq.size() > 0));
    if (ifq.size() > 0) chk("ifmap_data", 32'(ifmap_data), 32'(ifq[0][8:0]));
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("row_valid%0d", r), 32'(row_valid[r]), 32'(rq[r].size() > 0));
      if (rq[r].size() > 0)
        chk($sformatf("row_data%0d", r), 32'(row_data[r*FW +: FW]), 32'(rq[r][0]));
    end
  endtask

  // One clock: called at a falling edge, returns at the next falling edge.
  task automatic cyc(input logic v, input logic isf, input logic bc, input logic [1:0] row,
                     input logic [FW-1:0] d, input logic ir, input logic [NR-1:0] rr,
                     input logic lc, input logic ec);
    logic exp_ready, all_before, all_after, bad;
    logic [NR-1:0] hit;
    in_valid = v; in_is_filter = isf; in_bcast = bc; in_row = row; in_data = d;
    ifmap_ready = ir; row_ready = rr; load_clr = lc; err_clr = ec;
    #1;
    hit = '0;
    bad = 1'b0;
    if (!isf) exp_ready = (ifq.size() < DEPTH);
    else if (bc) begin
      exp_ready = 1'b1;
      for (int r = 0; r < NR; r++) if (rq[r].size() >= DEPTH) exp_ready = 1'b0;
      hit = '1;
    end else if (int'(row) >= NR) begin
      exp_ready = 1'b1;
      bad = 1'b1;
    end else begin
      exp_ready = (rq[row].size() < DEPTH);
      hit[row] = 1'b1;
    end
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    check_outputs();
    @(posedge clk);
    if (ir && ifq.size() > 0) void'(ifq.pop_front());
    for (int r = 0; r < NR; r++) if (rr[r] && rq[r].size() > 0) void'(rq[r].pop_front());
    if (v && exp_ready) begin
      if (!isf) ifq.push_back(d);
      for (int r = 0; r < NR; r++) if (hit[r]) rq[r].push_back(d);
    end else begin
      hit = '0;
      bad = 1'b0;
    end
    all_before = (m_loaded == '1);
    if (lc) m_loaded = '0;
    m_loaded = m_loaded | hit;
    all_after = (m_loaded == '1);
    m_pulse = all_after && !all_before;
    if (ec) m_err = 1'b0;
    if (bad) m_err = 1'b1;
    @(negedge clk);
    chk("row_loaded", 32'(row_loaded), 32'(m_loaded));
    chk("rows_all_loaded", 32'(rows_all_loaded), 32'(m_pulse));
    chk("err_row", 32'(err_row), 32'(m_err));
  endtask

  task automatic idle(input logic ir, input logic [NR-1:0] rr);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, '0, ir, rr, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state();
    chk("rst_ifmap_valid", 32'(ifmap_valid), 32'd0);
    chk("rst_row_valid", 32'(row_valid), 32'd0);
    chk("rst_ifmap_data", 32'(ifmap_data), 32'd0);
    chk("rst_row_data_or", 32'(|row_data), 32'd0);
    chk("rst_row_loaded", 32'(row_loaded), 32'd0);
    chk("rst_all_loaded", 32'(rows_all_loaded), 32'd0);
    chk("rst_err_row", 32'(err_row), 32'd0);
  endtask

  task automatic model_reset();
    ifq.delete();
    for (int r = 0; r < NR; r++) rq[r].delete();
    m_loaded = '0; m_pulse = 1'b0; m_err = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();

    // ifmap word passes through, no rows touched
    cyc(1, 0, 0, 0, 24'h0001A5, 1, 3'b000, 0, 0);
    chk("ifmap_1a5", 32'(ifmap_data), 32'h1A5);
    idle(1, 3'b000);

    // one filter word per row; mask walks 001, 011, 111
    cyc(1, 1, 0, 0, 24'h112233, 0, 3'b000, 0, 0);
    cyc(1, 1, 0, 1, 24'h445566, 0, 3'b000, 0, 0);
    cyc(1, 1, 0, 2, 24'h778899, 0, 3'b000, 0, 0);
    chk("all_loaded_pulse", 32'(rows_all_loaded), 32'd1);
    idle(0, 3'b111);
    chk("all_loaded_once", 32'(rows_all_loaded), 32'd0);

    // row 1 backpressure: third word refused, row 0 unaffected
    cyc(1, 1, 0, 1, 24'h000A01, 0, 3'b000, 0, 0);
    cyc(1, 1, 0, 1, 24'h000A02, 0, 3'b000, 0, 0);
    cyc(1, 1, 0, 1, 24'h000A03, 0, 3'b000, 0, 0);
    cyc(1, 1, 0, 0, 24'h000B00, 0, 3'b001, 0, 0);
    cyc(1, 1, 0, 1, 24'h000A03, 0, 3'b011, 0, 0);
    cyc(1, 1, 0, 1, 24'h000A03, 0, 3'b010, 0, 0);
    idle(0, 3'b111);
    idle(0, 3'b111);

    // broadcast blocked by a full row 2, never partially written
    cyc(1, 1, 0, 2, 24'h000C01, 0, 3'b000, 0, 0);
    cyc(1, 1, 0, 2, 24'h000C02, 0, 3'b000, 0, 0);
    cyc(1, 1, 1, 0, 24'hABCDEF, 0, 3'b000, 0, 0);
    cyc(1, 1, 1, 0, 24'hABCDEF, 0, 3'b100, 0, 0);
    cyc(1, 1, 1, 0, 24'hABCDEF, 0, 3'b100, 0, 0);
    idle(0, 3'b000);
    idle(0, 3'b111);

    // out-of-range row: dropped, error sticky until cleared
    cyc(1, 1, 0, 3, 24'h0DEAD0, 0, 3'b000, 1, 0);
    idle(0, 3'b000);
    idle(0, 3'b000);
    cyc(0, 0, 0, 0, '0, 0, 3'b000, 0, 1);
    // clear coinciding with a new bad word keeps the error set
    cyc(1, 1, 0, 3, 24'h0DEAD1, 0, 3'b000, 0, 1);

    // asynchronous reset while rows hold data
    cyc(1, 1, 0, 0, 24'h000E00, 0, 3'b000, 0, 0);
    cyc(1, 1, 0, 1, 24'h000E01, 0, 3'b000, 0, 0);
    chk("pre_reset_valid", 32'(row_valid), 32'b011);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_state();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
          2'($urandom_range(0, 3)), 24'($urandom), 1'($urandom), 3'($urandom),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
